decode_ctrl_stage: RTL and testbench

//  Registered ID-stage decoder for the 5-stage core, replacing the combinational control unit.

---
 rtl/core_ctrl_pkg.sv | 98 +++++++++
 rtl/decode_ctrl_stage_if.sv | 50 +++++
 rtl/decode_ctrl_comb.sv | 145 ++++++++++++++
 rtl/decode_ctrl_stage.sv | 106 ++++++++++
 tb/tb_decode_ctrl_stage.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/core_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_ctrl_pkg
// Description : Opcode, ALU, immediate, result, operand and memory-access
//               encodings shared by the ID-stage decoder and its consumers.
// Revision    : 1.0
// ============================================================================
package core_ctrl_pkg;

    localparam logic [6:0] c_OP_LOAD     = 7'b0000011;
    localparam logic [6:0] c_OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] c_OP_IMM      = 7'b0010011;
    localparam logic [6:0] c_OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] c_OP_STORE    = 7'b0100011;
    localparam logic [6:0] c_OP_REG      = 7'b0110011;
    localparam logic [6:0] c_OP_LUI      = 7'b0110111;
    localparam logic [6:0] c_OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] c_OP_JALR     = 7'b1100111;
    localparam logic [6:0] c_OP_JAL      = 7'b1101111;

    localparam logic [6:0] c_F7_BASE     = 7'b0000000;
    localparam logic [6:0] c_F7_ALT      = 7'b0100000;
    localparam logic [6:0] c_F7_MULDIV   = 7'b0000001;

    localparam logic [4:0] c_ALU_ADD     = 5'd0;
    localparam logic [4:0] c_ALU_SUB     = 5'd1;
    localparam logic [4:0] c_ALU_AND     = 5'd2;
    localparam logic [4:0] c_ALU_OR      = 5'd3;
    localparam logic [4:0] c_ALU_XOR     = 5'd4;
    localparam logic [4:0] c_ALU_SLL     = 5'd5;
    localparam logic [4:0] c_ALU_SRL     = 5'd6;
    localparam logic [4:0] c_ALU_SRA     = 5'd7;
    localparam logic [4:0] c_ALU_SLT     = 5'd8;
    localparam logic [4:0] c_ALU_SLTU    = 5'd9;
    localparam logic [4:0] c_ALU_MUL     = 5'd10;

    localparam logic [2:0] c_IMM_I       = 3'b000;
    localparam logic [2:0] c_IMM_S       = 3'b001;
    localparam logic [2:0] c_IMM_B       = 3'b010;
    localparam logic [2:0] c_IMM_U       = 3'b011;
    localparam logic [2:0] c_IMM_J       = 3'b100;

    localparam logic [1:0] c_RES_SRC_ALU = 2'b00;
    localparam logic [1:0] c_RES_SRC_MEM = 2'b01;
    localparam logic [1:0] c_RES_SRC_PC4 = 2'b10;

    localparam logic [1:0] c_ASRC_RS1    = 2'b00;
    localparam logic [1:0] c_ASRC_PC     = 2'b01;
    localparam logic [1:0] c_ASRC_ZERO   = 2'b10;

    localparam logic [2:0] c_LOAD_W      = 3'b000;
    localparam logic [2:0] c_LOAD_H      = 3'b001;
    localparam logic [2:0] c_LOAD_B      = 3'b010;
    localparam logic [2:0] c_LOAD_HU     = 3'b011;
    localparam logic [2:0] c_LOAD_BU     = 3'b111;

    localparam logic [1:0] c_STORE_W     = 2'b00;
    localparam logic [1:0] c_STORE_H     = 2'b01;
    localparam logic [1:0] c_STORE_B     = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic [1:0] result_src;
        logic [2:0] imm_src;
        logic [1:0] alu_a_src;
        logic       alu_src;
        logic [4:0] alu_ctrl;
        logic       branch;
        logic [2:0] branch_cond;
        logic       jump;
        logic       jalr;
        logic [2:0] load_type;
        logic [1:0] store_type;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       illegal;
    } ctrl_bundle_t;

    // Base-integer ALU op from funct3; alt selects SUB/SRA over ADD/SRL.
    function automatic logic [4:0] alu_base_op(input logic [2:0] f3, input logic alt);
        logic [4:0] op;
        case (f3)
            3'b000:  op = alt ? c_ALU_SUB : c_ALU_ADD;
            3'b001:  op = c_ALU_SLL;
            3'b010:  op = c_ALU_SLT;
            3'b011:  op = c_ALU_SLTU;
            3'b100:  op = c_ALU_XOR;
            3'b101:  op = alt ? c_ALU_SRA : c_ALU_SRL;
            3'b110:  op = c_ALU_OR;
            default: op = c_ALU_AND;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_ctrl_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_ctrl_stage_if
// Description : IF/ID-to-EX handshake and control-bundle bus of the ID stage.
// Revision    : 1.0
// ============================================================================
interface decode_ctrl_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic            reg_write;
    logic            mem_write;
    logic [1:0]      result_src;
    logic [2:0]      imm_src;
    logic [1:0]      alu_a_src;
    logic            alu_src;
    logic [4:0]      alu_ctrl;
    logic            branch;
    logic [2:0]      branch_cond;
    logic            jump;
    logic            jalr;
    logic [2:0]      load_type;
    logic [1:0]      store_type;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] pc_out;
    logic            illegal;

    modport master (
        output in_valid, instr, pc, flush, out_ready,
        input  in_ready, out_valid, reg_write, mem_write, result_src, imm_src,
               alu_a_src, alu_src, alu_ctrl, branch, branch_cond, jump, jalr,
               load_type, store_type, rd, rs1, rs2, pc_out, illegal
    );

    modport slave (
        input  in_valid, instr, pc, flush, out_ready,
        output in_ready, out_valid, reg_write, mem_write, result_src, imm_src,
               alu_a_src, alu_src, alu_ctrl, branch, branch_cond, jump, jalr,
               load_type, store_type, rd, rs1, rs2, pc_out, illegal
    );
endinterface
`default_nettype wire

// File: rtl/decode_ctrl_comb.sv
`default_nettype none
// ============================================================================
// Module      : decode_ctrl_comb
// Description : Pure combinational RV32I(+M) instruction to control-bundle
//               decode with illegal-encoding and divide detection.
// Revision    : 1.0
// ============================================================================
module decode_ctrl_comb
    import core_ctrl_pkg::*;
#(
    parameter int EN_M = 1
) (
    input  wire logic [31:0]  i_instr,
    output ctrl_bundle_t      o_ctrl,
    output logic              o_is_div
);

    logic [6:0]   w_opcode;
    logic [2:0]   w_f3;
    logic [6:0]   w_f7;
    ctrl_bundle_t w_dec;
    logic         w_ill;
    logic         w_div;

    assign w_opcode = i_instr[6:0];
    assign w_f3     = i_instr[14:12];
    assign w_f7     = i_instr[31:25];

    always_comb begin
        w_dec      = '0;
        w_ill      = 1'b0;
        w_div      = 1'b0;
        w_dec.rd   = i_instr[11:7];
        w_dec.rs1  = i_instr[19:15];
        w_dec.rs2  = i_instr[24:20];
        case (w_opcode)
            c_OP_REG: begin
                w_dec.reg_write = 1'b1;
                if (w_f7 == c_F7_BASE) begin
                    w_dec.alu_ctrl = alu_base_op(w_f3, 1'b0);
                end else if (w_f7 == c_F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101)) begin
                    w_dec.alu_ctrl = alu_base_op(w_f3, 1'b1);
                end else if (w_f7 == c_F7_MULDIV && EN_M != 0) begin
                    // MUL..REMU are contiguous codes indexed by funct3.
                    w_dec.alu_ctrl = c_ALU_MUL + {2'b00, w_f3};
                    w_div          = w_f3[2];
                end else begin
                    w_ill = 1'b1;
                end
            end
            c_OP_IMM: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.imm_src   = c_IMM_I;
                if (w_f3 == 3'b001) begin
                    w_dec.alu_ctrl = c_ALU_SLL;
                    w_ill          = (w_f7 != c_F7_BASE);
                end else if (w_f3 == 3'b101) begin
                    w_dec.alu_ctrl = (w_f7 == c_F7_ALT) ? c_ALU_SRA : c_ALU_SRL;
                    w_ill          = (w_f7 != c_F7_BASE) && (w_f7 != c_F7_ALT);
                end else begin
                    w_dec.alu_ctrl = alu_base_op(w_f3, 1'b0);
                end
            end
            c_OP_LOAD: begin
                w_dec.reg_write  = 1'b1;
                w_dec.result_src = c_RES_SRC_MEM;
                w_dec.alu_src    = 1'b1;
                w_dec.imm_src    = c_IMM_I;
                case (w_f3)
                    3'b000:  w_dec.load_type = c_LOAD_B;
                    3'b001:  w_dec.load_type = c_LOAD_H;
                    3'b010:  w_dec.load_type = c_LOAD_W;
                    3'b100:  w_dec.load_type = c_LOAD_BU;
                    3'b101:  w_dec.load_type = c_LOAD_HU;
                    default: w_ill = 1'b1;
                endcase
            end
            c_OP_STORE: begin
                w_dec.mem_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.imm_src   = c_IMM_S;
                case (w_f3)
                    3'b000:  w_dec.store_type = c_STORE_B;
                    3'b001:  w_dec.store_type = c_STORE_H;
                    3'b010:  w_dec.store_type = c_STORE_W;
                    default: w_ill = 1'b1;
                endcase
            end
            c_OP_BRANCH: begin
                w_dec.branch      = 1'b1;
                w_dec.imm_src     = c_IMM_B;
                w_dec.alu_ctrl    = c_ALU_SUB;
                w_dec.branch_cond = w_f3;
                w_ill             = (w_f3 == 3'b010) || (w_f3 == 3'b011);
            end
            c_OP_JAL: begin
                w_dec.reg_write  = 1'b1;
                w_dec.jump       = 1'b1;
                w_dec.result_src = c_RES_SRC_PC4;
                w_dec.imm_src    = c_IMM_J;
            end
            c_OP_JALR: begin
                w_dec.reg_write  = 1'b1;
                w_dec.jump       = 1'b1;
                w_dec.jalr       = 1'b1;
                w_dec.result_src = c_RES_SRC_PC4;
                w_dec.alu_src    = 1'b1;
                w_dec.imm_src    = c_IMM_I;
                w_ill            = (w_f3 != 3'b000);
            end
            c_OP_LUI: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_a_src = c_ASRC_ZERO;
                w_dec.alu_src   = 1'b1;
                w_dec.imm_src   = c_IMM_U;
            end
            c_OP_AUIPC: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_a_src = c_ASRC_PC;
                w_dec.alu_src   = 1'b1;
                w_dec.imm_src   = c_IMM_U;
            end
            // FENCE is a no-op on this in-order core with a single memory port.
            c_OP_MISC_MEM: ;
            default: w_ill = 1'b1;
        endcase
    end

    // An illegal encoding carries only its register indices and the flag.
    always_comb begin
        o_ctrl   = w_dec;
        o_is_div = w_div;
        if (w_ill) begin
            o_ctrl         = '0;
            o_ctrl.rd      = w_dec.rd;
            o_ctrl.rs1     = w_dec.rs1;
            o_ctrl.rs2     = w_dec.rs2;
            o_ctrl.illegal = 1'b1;
            o_is_div       = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/decode_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_ctrl_stage
// Description : Registered ID-stage decoder with valid/ready handshake, flush
//               and a DIV/REM issue-hold counter.
// Revision    : 1.0
// ============================================================================
module decode_ctrl_stage
    import core_ctrl_pkg::*;
#(
    parameter int EN_M        = 1,
    parameter int DIV_LATENCY = 34,
    parameter int XLEN        = 32
) (
    input wire logic           clk,
    input wire logic           rst,
    decode_ctrl_stage_if.slave bus
);

    localparam int                 c_CNT_W     = $clog2(DIV_LATENCY + 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LOAD = c_CNT_W'(DIV_LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [0:0]         c_ST_IDLE   = 1'b0;
    localparam logic [0:0]         c_ST_HOLD   = 1'b1;

    ctrl_bundle_t       w_dec;
    logic               w_is_div;
    logic               w_in_ready;
    logic               w_accept;

    ctrl_bundle_t       r_ctl;
    logic [XLEN-1:0]    r_pc;
    logic               r_out_valid;
    logic [0:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;

    decode_ctrl_comb #(
        .EN_M     (EN_M)
    ) u_decode (
        .i_instr  (bus.instr),
        .o_ctrl   (w_dec),
        .o_is_div (w_is_div)
    );

    assign w_in_ready = !bus.flush && (r_state == c_ST_IDLE) && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctl       <= '0;
            r_pc        <= '0;
            r_out_valid <= 1'b0;
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
        end else begin
            if (w_accept) begin
                r_ctl       <= w_dec;
                r_pc        <= bus.pc;
                r_out_valid <= 1'b1;
                // Accept only happens in IDLE, so this never collides with HOLD.
                if (w_is_div && (DIV_LATENCY > 1)) begin
                    r_state <= c_ST_HOLD;
                    r_cnt   <= c_HOLD_LOAD;
                end
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (r_state == c_ST_HOLD) begin
                if (r_cnt == c_CNT_ONE) begin
                    r_state <= c_ST_IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_cnt   <= r_cnt - c_CNT_ONE;
                end
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.reg_write   = r_ctl.reg_write;
    assign bus.mem_write   = r_ctl.mem_write;
    assign bus.result_src  = r_ctl.result_src;
    assign bus.imm_src     = r_ctl.imm_src;
    assign bus.alu_a_src   = r_ctl.alu_a_src;
    assign bus.alu_src     = r_ctl.alu_src;
    assign bus.alu_ctrl    = r_ctl.alu_ctrl;
    assign bus.branch      = r_ctl.branch;
    assign bus.branch_cond = r_ctl.branch_cond;
    assign bus.jump        = r_ctl.jump;
    assign bus.jalr        = r_ctl.jalr;
    assign bus.load_type   = r_ctl.load_type;
    assign bus.store_type  = r_ctl.store_type;
    assign bus.rd          = r_ctl.rd;
    assign bus.rs1         = r_ctl.rs1;
    assign bus.rs2         = r_ctl.rs2;
    assign bus.pc_out      = r_pc;
    assign bus.illegal     = r_ctl.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_ctrl_stage
// Description : Directed table-driven bench for decode_ctrl_stage (EN_M=1 and
//               EN_M=0 instances, DIV_LATENCY=4).
// Revision    : 1.0
// ============================================================================
module tb_decode_ctrl_stage;

    typedef struct packed {
        logic       rw;
        logic       mw;
        logic [1:0] rsrc;
        logic [2:0] imm;
        logic [1:0] asrc;
        logic       asel;
        logic [4:0] alu;
        logic       br;
        logic [2:0] bc;
        logic       j;
        logic       jr;
        logic [2:0] lt;
        logic [1:0] st;
        logic       ill;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ctl_t;

    typedef struct packed {
        logic [31:0] instr;
        ctl_t        exp;
    } vec_t;

    localparam int c_NVEC = 19;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t tbl [c_NVEC];

    decode_ctrl_stage_if #(.XLEN(32)) bus_m ();
    decode_ctrl_stage_if #(.XLEN(32)) bus_n ();

    decode_ctrl_stage #(.EN_M(1), .DIV_LATENCY(4), .XLEN(32)) u_dut_m (.clk(clk), .rst(rst), .bus(bus_m));
    decode_ctrl_stage #(.EN_M(0), .DIV_LATENCY(4), .XLEN(32)) u_dut_n (.clk(clk), .rst(rst), .bus(bus_n));

    assign bus_n.in_valid  = bus_m.in_valid;
    assign bus_n.instr     = bus_m.instr;
    assign bus_n.pc        = bus_m.pc;
    assign bus_n.flush     = bus_m.flush;
    assign bus_n.out_ready = bus_m.out_ready;

    always #5 clk = ~clk;

    function automatic ctl_t act_m();
        ctl_t a;
        a.rw = bus_m.reg_write;    a.mw = bus_m.mem_write;  a.rsrc = bus_m.result_src;
        a.imm = bus_m.imm_src;     a.asrc = bus_m.alu_a_src; a.asel = bus_m.alu_src;
        a.alu = bus_m.alu_ctrl;    a.br = bus_m.branch;     a.bc = bus_m.branch_cond;
        a.j = bus_m.jump;          a.jr = bus_m.jalr;       a.lt = bus_m.load_type;
        a.st = bus_m.store_type;   a.ill = bus_m.illegal;   a.rd = bus_m.rd;
        a.rs1 = bus_m.rs1;         a.rs2 = bus_m.rs2;
        return a;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            instr          rw mw rsrc   imm     asrc  as alu     br bc     j  jr lt      st     il rd     rs1    rs2
        tbl[0]  = '{32'h002081B3, '{1, 0, 2'b00, 3'b000, 2'b00, 0, 5'd0,  0, 3'b000, 0, 0, 3'b000, 2'b00, 0, 5'd3,  5'd1, 5'd2}};
        tbl[1]  = '{32'h00812283, '{1, 0, 2'b01, 3'b000, 2'b00, 1, 5'd0,  0, 3'b000, 0, 0, 3'b000, 2'b00, 0, 5'd5,  5'd2, 5'd8}};
        tbl[2]  = '{32'h123450B7, '{1, 0, 2'b00, 3'b011, 2'b10, 1, 5'd0,  0, 3'b000, 0, 0, 3'b000, 2'b00, 0, 5'd1,  5'd8, 5'd3}};
        tbl[3]  = '{32'h0020D063, '{0, 0, 2'b00, 3'b010, 2'b00, 0, 5'd1,  1, 3'b101, 0, 0, 3'b000, 2'b00, 0, 5'd0,  5'd1, 5'd2}};
        tbl[4]  = '{32'h00000000, '{0, 0, 2'b00, 3'b000, 2'b00, 0, 5'd0,  0, 3'b000, 0, 0, 3'b000, 2'b00, 1, 5'd0,  5'd0, 5'd0}};
        tbl[5]  = '{32'h00512623, '{0, 1, 2'b00, 3'b001, 2'b00, 1, 5'd0,  0, 3'b000, 0, 0, 3'b000, 2'b00, 0, 5'd12, 5'd2, 5'd5}};
        tbl[6]  = '{32'h00510023, '{0, 1, 2'b00, 3'b001, 2'b00, 1, 5'd0,  0, 3'b000, 0, 0, 3'b000, 2'b10, 0, 5'd0,  5'd2, 5'd5}};
        tbl[7]  = '{32'h0000C303, '{1, 0, 2'b01, 3'b000, 2'b00, 1, 5'd0,  0, 3'b000, 0, 0, 3'b111, 2'b00, 0, 5'd6,  5'd1, 5'd0}};
        tbl[8]  = '{32'h00009383, '{1, 0, 2'b01, 3'b000, 2'b00, 1, 5'd0,  0, 3'b000, 0, 0, 3'b001, 2'b00, 0, 5'd7,  5'd1, 5'd0}};
        tbl[9]  = '{32'h0000B383, '{0, 0, 2'b00, 3'b000, 2'b00, 0, 5'd0,  0, 3'b000, 0, 0, 3'b000, 2'b00, 1, 5'd7,  5'd1, 5'd0}};
        tbl[10] = '{32'h008000EF, '{1, 0, 2'b10, 3'b100, 2'b00, 0, 5'd0,  0, 3'b000, 1, 0, 3'b000, 2'b00, 0, 5'd1,  5'd0, 5'd8}};
        tbl[11] = '{32'h00008067, '{1, 0, 2'b10, 3'b000, 2'b00, 1, 5'd0,  0, 3'b000, 1, 1, 3'b000, 2'b00, 0, 5'd0,  5'd1, 5'd0}};
        tbl[12] = '{32'h00001217, '{1, 0, 2'b00, 3'b011, 2'b01, 1, 5'd0,  0, 3'b000, 0, 0, 3'b000, 2'b00, 0, 5'd4,  5'd0, 5'd0}};
        tbl[13] = '{32'h402081B3, '{1, 0, 2'b00, 3'b000, 2'b00, 0, 5'd1,  0, 3'b000, 0, 0, 3'b000, 2'b00, 0, 5'd3,  5'd1, 5'd2}};
        tbl[14] = '{32'h4030D293, '{1, 0, 2'b00, 3'b000, 2'b00, 1, 5'd7,  0, 3'b000, 0, 0, 3'b000, 2'b00, 0, 5'd5,  5'd1, 5'd3}};
        tbl[15] = '{32'h40309293, '{0, 0, 2'b00, 3'b000, 2'b00, 0, 5'd0,  0, 3'b000, 0, 0, 3'b000, 2'b00, 1, 5'd5,  5'd1, 5'd3}};
        tbl[16] = '{32'h0020A063, '{0, 0, 2'b00, 3'b000, 2'b00, 0, 5'd0,  0, 3'b000, 0, 0, 3'b000, 2'b00, 1, 5'd0,  5'd1, 5'd2}};
        tbl[17] = '{32'h022081B3, '{1, 0, 2'b00, 3'b000, 2'b00, 0, 5'd10, 0, 3'b000, 0, 0, 3'b000, 2'b00, 0, 5'd3,  5'd1, 5'd2}};
        tbl[18] = '{32'h00513623, '{0, 0, 2'b00, 3'b000, 2'b00, 0, 5'd0,  0, 3'b000, 0, 0, 3'b000, 2'b00, 1, 5'd12, 5'd2, 5'd5}};

        rst = 1'b1;
        bus_m.in_valid = 1'b0; bus_m.instr = '0; bus_m.pc = '0;
        bus_m.flush = 1'b0;    bus_m.out_ready = 1'b1;
        repeat (2) tick();
        check("rst_out_valid", 64'(bus_m.out_valid), 64'd0);
        check("rst_bundle", 64'(act_m()), 64'd0);
        check("rst_pc_out", 64'(bus_m.pc_out), 64'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 64'(bus_m.in_ready), 64'd1);

        for (int i = 0; i < c_NVEC; i++) begin
            bus_m.in_valid = 1'b1;
            bus_m.instr    = tbl[i].instr;
            bus_m.pc       = 32'h1000 + 32'(i * 4);
            tick();
            check($sformatf("vec%0d_bundle", i), 64'(act_m()), 64'(tbl[i].exp));
            check($sformatf("vec%0d_out_valid", i), 64'(bus_m.out_valid), 64'd1);
            check($sformatf("vec%0d_pc_out", i), 64'(bus_m.pc_out), 64'(32'h1000 + 32'(i * 4)));
        end
        bus_m.in_valid = 1'b0;
        tick();
        check("drain_out_valid", 64'(bus_m.out_valid), 64'd0);

        // Output stall: add held for two cycles while lw waits upstream.
        bus_m.out_ready = 1'b0;
        bus_m.in_valid = 1'b1; bus_m.instr = 32'h002081B3; bus_m.pc = 32'h2000;
        tick();
        check("stall_in_ready", 64'(bus_m.in_ready), 64'd0);
        bus_m.instr = 32'h00812283; bus_m.pc = 32'h2004;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("stall_out_valid", 64'(bus_m.out_valid), 64'd1);
            check("stall_bundle", 64'(act_m()), 64'(tbl[0].exp));
            check("stall_pc_out", 64'(bus_m.pc_out), 64'h2000);
        end
        bus_m.out_ready = 1'b1;
        tick();
        check("unstall_bundle", 64'(act_m()), 64'(tbl[1].exp));
        check("unstall_pc_out", 64'(bus_m.pc_out), 64'h2004);
        bus_m.in_valid = 1'b0;
        tick();
        check("unstall_drain", 64'(bus_m.out_valid), 64'd0);

        // DIV hold: in_ready low for DIV_LATENCY-1 cycles after accept.
        bus_m.in_valid = 1'b1; bus_m.instr = 32'h0220C1B3; bus_m.pc = 32'h3000;
        tick();
        check("div_alu_ctrl", 64'(bus_m.alu_ctrl), 64'd14);
        check("div_out_valid", 64'(bus_m.out_valid), 64'd1);
        check("div_in_ready_0", 64'(bus_m.in_ready), 64'd0);
        check("div_nom_illegal", 64'(bus_n.illegal), 64'd1);
        check("div_nom_reg_write", 64'(bus_n.reg_write), 64'd0);
        check("div_nom_in_ready", 64'(bus_n.in_ready), 64'd1);
        bus_m.in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("div_in_ready_%0d", k), 64'(bus_m.in_ready), (k == 3) ? 64'd1 : 64'd0);
        end
        check("div_out_valid_done", 64'(bus_m.out_valid), 64'd0);

        // Flush in the middle of HOLD, with an incoming instruction dropped.
        bus_m.out_ready = 1'b0;
        bus_m.in_valid = 1'b1; bus_m.instr = 32'h0220C1B3; bus_m.pc = 32'h4000;
        tick();
        bus_m.in_valid = 1'b0;
        tick();
        check("hold_out_valid", 64'(bus_m.out_valid), 64'd1);
        bus_m.flush = 1'b1;
        bus_m.in_valid = 1'b1; bus_m.instr = 32'h002081B3; bus_m.pc = 32'h4004;
        #1;
        check("flush_in_ready", 64'(bus_m.in_ready), 64'd0);
        tick();
        check("flush_out_valid", 64'(bus_m.out_valid), 64'd0);
        bus_m.flush = 1'b0;
        bus_m.in_valid = 1'b0;
        #1;
        check("post_flush_in_ready", 64'(bus_m.in_ready), 64'd1);
        tick();
        check("post_flush_dropped", 64'(bus_m.out_valid), 64'd0);

        // Reset while in HOLD with a stalled output.
        bus_m.in_valid = 1'b1; bus_m.instr = 32'h0220C1B3; bus_m.pc = 32'h5000;
        tick();
        bus_m.in_valid = 1'b0;
        check("pre_rst_in_ready", 64'(bus_m.in_ready), 64'd0);
        rst = 1'b1;
        tick();
        check("rst_hold_out_valid", 64'(bus_m.out_valid), 64'd0);
        check("rst_hold_bundle", 64'(act_m()), 64'd0);
        check("rst_hold_pc_out", 64'(bus_m.pc_out), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_hold_in_ready", 64'(bus_m.in_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
